// File: rtl/sng_lfsr8.sv
// -----------------------------------------------------------------------------
// sng_lfsr8 -- 8-bit stochastic number generator core.
//
// A maximal-length Fibonacci LFSR (x^8 + x^6 + x^5 + x^4 + 1) that produces
// one pseudo-random 8-bit value per enabled clock. Downstream stochastic
// comparators use this value to turn binary operands into bitstreams.
//
// Ports:
//   clk     in   1  system clock, all state changes on the rising edge
//   reset   in   1  synchronous, active-high; loads the seed (0 is mapped to 1)
//   enable  in   1  advance the LFSR one step per clock while high
//   seed    in   8  initial state, only looked at while reset is high
//   data    out  8  current LFSR state, driven straight from the register
//
// The sequence has period 255 and never visits 8'h00 once reset. Before the
// first reset the state is undefined.
// -----------------------------------------------------------------------------
module sng_lfsr8 (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] seed,
  output logic [7:0] data
);

  logic [7:0] r_state;
  logic       w_feedback;
  logic [7:0] w_seed_safe;
  logic [7:0] w_state_next;

  // Taps at bits 7,5,4,3 correspond to the polynomial terms x^8,x^6,x^5,x^4.
  assign w_feedback = r_state[7] ^ r_state[5] ^ r_state[4] ^ r_state[3];

  // An all-zero state is a fixed point of the XOR feedback and would lock the
  // generator up forever, so a zero seed is replaced by 8'h01.
  assign w_seed_safe = (seed == 8'h00) ? 8'h01 : seed;

  // Shift toward the MSB and insert the feedback bit at the LSB.
  assign w_state_next = {r_state[6:0], w_feedback};

  // NOTE: state registers are written with non-blocking assignments so every
  // flop samples its inputs from before the edge, independent of block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= w_seed_safe;
    end else if (enable) begin
      r_state <= w_state_next;
    end
  end

  assign data = r_state;

endmodule

// File: tb/tb_sng_lfsr8.sv
// -----------------------------------------------------------------------------
// tb_sng_lfsr8 -- scoreboard bench for sng_lfsr8.
//
// The driver applies one input set per cycle on the falling edge and pushes
// the value data must hold after the following rising edge. A separate monitor
// pops one entry per rising edge and compares it against the DUT. Expected
// values come from directed constants or from a reference model that treats
// the LFSR as multiply-by-two modulo 256 plus the parity of the polynomial
// taps.
// -----------------------------------------------------------------------------
module tb_sng_lfsr8;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [7:0] seed;
  logic [7:0] data;

  sng_lfsr8 dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .seed   (seed),
    .data   (data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] exp;
    int         tag;
    bit         cap;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] cap_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         step_no  = 0;
  logic [7:0] m_state;

  // Polynomial x^8+x^6+x^5+x^4+1: the feedback taps are the bits below the
  // exponents 8,6,5,4.
  localparam logic [7:0] TAPS = 8'b1011_1000;

  function automatic logic [7:0] ref_next(input logic rst, input logic en,
                                          input logic [7:0] sd,
                                          input logic [7:0] cur);
    int v;
    if (rst) return (sd == 8'h00) ? 8'h01 : sd;
    if (!en) return cur;
    v = (int'(cur) * 2) % 256 + ($countones(cur & TAPS) % 2);
    return 8'(v);
  endfunction

  task automatic check(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Apply one cycle of stimulus and record what data must become.
  task automatic drive(input logic rst, input logic en, input logic [7:0] sd,
                       input logic [7:0] exp, input bit cap = 1'b0);
    exp_t e;
    @(negedge clk);
    reset  = rst;
    enable = en;
    seed   = sd;
    e.exp  = exp;
    e.tag  = step_no;
    e.cap  = cap;
    sb_q.push_back(e);
    step_no++;
    m_state = exp;
  endtask

  // Drive a cycle whose expectation comes from the reference model.
  task automatic drive_model(input logic rst, input logic en,
                             input logic [7:0] sd, input bit cap = 1'b0);
    drive(rst, en, sd, ref_next(rst, en, sd, m_state), cap);
  endtask

  task automatic drain();
    int budget = 50;
    while (sb_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #2;
    check_int("scoreboard_drain", sb_q.size(), 0);
  endtask

  // Monitor: data is presented every cycle, one entry per rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check($sformatf("data step %0d", e.tag), data, e.exp);
      if (e.cap) cap_q.push_back(data);
    end
  end

  initial begin
    bit seen[256];
    int zeros;
    int distinct;

    reset  = 1'b1;
    enable = 1'b0;
    seed   = 8'h21;
    m_state = 8'h00;

    // Seed and step, with a hold in the middle.
    drive(1'b1, 1'b0, 8'h21, 8'h21);
    drive(1'b1, 1'b1, 8'h21, 8'h21);
    drive(1'b0, 1'b1, 8'h21, 8'h43);
    drive(1'b0, 1'b1, 8'h21, 8'h86);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 8'($urandom), 8'h86);
    drive(1'b0, 1'b1, 8'h21, 8'h0D);
    drive(1'b0, 1'b1, 8'h21, 8'h1B);

    // Full period from 8'h21 with random (ignored) seed values.
    drive(1'b1, 1'b0, 8'h21, 8'h21);
    for (int i = 0; i < 255; i++) drive_model(1'b0, 1'b1, 8'($urandom), 1'b1);
    drain();
    check_int("period_len", cap_q.size(), 255);
    if (cap_q.size() == 255) begin
      check("period_return", cap_q[254], 8'h21);
      foreach (seen[i]) seen[i] = 1'b0;
      zeros = 0;
      distinct = 0;
      foreach (cap_q[i]) begin
        if (cap_q[i] == 8'h00) zeros++;
        if (!seen[cap_q[i]]) distinct++;
        seen[cap_q[i]] = 1'b1;
      end
      check_int("period_zero_count", zeros, 0);
      check_int("period_distinct", distinct, 255);
    end

    // Zero seed is remapped to 8'h01.
    drive(1'b1, 1'b0, 8'h00, 8'h01);
    drive(1'b0, 1'b1, 8'h00, 8'h02);
    drive(1'b0, 1'b1, 8'h00, 8'h04);
    drive(1'b0, 1'b1, 8'h00, 8'h08);

    // Seed changes without reset are ignored; a one-edge reset reloads it.
    for (int i = 0; i < 3; i++) drive_model(1'b0, 1'b1, 8'hA5);
    drive(1'b1, 1'b1, 8'hA5, 8'hA5);
    drive_model(1'b0, 1'b1, 8'hA5);
    drive_model(1'b0, 1'b1, 8'h3C);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      drive_model(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
                  (($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom)));
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sng_lfsr8.md
Name: sng_lfsr8

Overview:
- 8-bit stochastic number generator (SNG) core: a maximal-length Fibonacci LFSR that produces one pseudo-random 8-bit value per enabled clock.
- Seeded from an external seed value at reset.
- Output is the random source that downstream stochastic-computing comparators use to convert binary values into bitstreams.

Parameters:
- none (width fixed at 8 bits; polynomial fixed at x^8+x^6+x^5+x^4+1)

Ports:
- clk     input   1  system clock; all state updates on rising edge
- reset   input   1  synchronous, active-high reset; loads the seed
- enable  input   1  advance LFSR one step per clock when high
- seed    input   8  initial LFSR state; sampled only while reset is high
- data    output  8  current LFSR state (registered)

Behaviour:
- Interface (already decided): one clock `clk`; `reset` is synchronous and active-high.
- All logic is in a single clock domain; data is driven directly from the state register, with no combinational path from inputs to data.
- Reset:
  - On a rising edge with reset=1, data <= seed.
  - If seed==8'h00, data <= 8'h01 instead, so the LFSR never enters the all-zero lock-up state.
  - Reset has priority over enable.
  - Reset asserted mid-operation reloads the seed on the next edge, regardless of enable.
- Step (reset=0, enable=1):
  - fb = data[7]^data[5]^data[4]^data[3]
  - data <= {data[6:0], fb}, i.e. shift left and insert the feedback bit at the LSB.
- Hold (reset=0, enable=0): data keeps its value.
- Latency: the new value is visible one clock after the enabled edge; one step per enabled cycle, with no internal pipeline.
- Sequence properties:
  - Period is 255 for any nonzero state.
  - 8'h00 never appears after reset.
  - Each value 8'h01..8'hFF appears exactly once per period.
- Seed usage: seed is ignored when reset=0; changing seed without reset has no effect on data.
- Before the first reset, data is unspecified; users must reset before use.
- No X propagation: with a defined seed during reset, data is fully defined from the first edge after reset.

Test Plan:
- Seed and step: reset=1, seed=8'h21 for 1+ edges -> data=8'h21. Then reset=0, enable=1 -> successive edges give 8'h43, 8'h86, 8'h0D, 8'h1B.
- Hold: after reaching 8'h86, drive enable=0 for 5 cycles -> data stays 8'h86. Re-enable -> 8'h0D.
- Full period: seed 8'h21, run 255 enabled cycles -> data returns to 8'h21; all 255 intermediate values are distinct and nonzero.
- Zero seed: reset with seed=8'h00 -> data=8'h01. Enabled steps -> 8'h02, 8'h04, 8'h08.
- Mid-run reset and seed isolation:
  - Change seed to 8'hA5 while running with reset=0 -> sequence unaffected.
  - Assert reset for one edge with enable=1 -> data=8'hA5 on that edge.
  - Release reset -> stepping resumes from 8'hA5.
